// File: rtl/exu_pipe_reg_pkg.sv
// Shared types for the stage pipeline register.
// Reset level and occupancy state codes.
package exu_pipe_reg_pkg;

  localparam logic RESET_ENABLE = 1'b0;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_TWO   = 2'd2
  } pipe_cnt_e;

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter with sync reset.
// Counts cycles where the output side is stalled.
module pipe_stall_counter
  import exu_pipe_reg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/exu_pipe_reg.sv
// Stage register with valid/ready, optional skid entry,
// flush and saturating stall counter.
module exu_pipe_reg
  import exu_pipe_reg_pkg::*;
#(
  parameter int PAYLOAD_W = 200,
  parameter bit SKID_EN   = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_data_o,
  output logic [1:0]           count_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  pipe_cnt_e            state_q;
  pipe_cnt_e            state_d;
  logic [PAYLOAD_W-1:0] out_q;
  logic [PAYLOAD_W-1:0] skid_q;
  logic                 in_ready;
  logic                 out_valid;
  logic                 in_fire;
  logic                 out_fire;
  logic                 load_in;
  logic                 load_skid;
  logic                 load_from_skid;
  logic                 stall;

  assign out_valid = (state_q != PIPE_EMPTY);
  assign in_fire   = in_valid_i && in_ready;
  assign out_fire  = out_valid && out_ready_i;

  // Occupancy transitions; flush wins and blocks all loads.
  always_comb begin
    state_d        = state_q;
    load_in        = 1'b0;
    load_skid      = 1'b0;
    load_from_skid = 1'b0;
    unique case (state_q)
      PIPE_EMPTY: begin
        if (in_fire) begin
          state_d = PIPE_ONE;
          load_in = 1'b1;
        end
      end
      PIPE_ONE: begin
        if (in_fire && out_fire) begin
          load_in = 1'b1;
        end else if (in_fire) begin
          state_d   = PIPE_TWO;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = PIPE_EMPTY;
        end
      end
      PIPE_TWO: begin
        if (out_fire) begin
          state_d        = PIPE_ONE;
          load_from_skid = 1'b1;
        end
      end
      default: state_d = PIPE_EMPTY;
    endcase
    if (flush_i) begin
      state_d        = PIPE_EMPTY;
      load_in        = 1'b0;
      load_skid      = 1'b0;
      load_from_skid = 1'b0;
    end
  end

  // State and output payload registers.
  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      state_q <= PIPE_EMPTY;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_in) begin
        out_q <= in_data_i;
      end else if (load_from_skid) begin
        out_q <= skid_q;
      end
    end
  end

  if (SKID_EN) begin : g_skid
    // Skid entry; ready depends only on state.
    always_ff @(posedge clock) begin
      if (reset == RESET_ENABLE) begin
        skid_q <= '0;
      end else if (load_skid) begin
        skid_q <= in_data_i;
      end
    end
    assign in_ready = (state_q != PIPE_TWO);
  end else begin : g_noskid
    assign skid_q   = '0;
    assign in_ready = !out_valid || out_ready_i;
  end

  assign stall = out_valid && !out_ready_i && !flush_i;

  pipe_stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall (
    .clock(clock),
    .reset(reset),
    .inc_i(stall),
    .cnt_o(stall_cnt_o)
  );

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid;
  assign out_data_o  = out_q;
  assign count_o     = state_q;

endmodule

// File: tb/tb_exu_pipe_reg.sv
// Bench for exu_pipe_reg: skid and no-skid instances,
// vector table plus queue scoreboard.
module tb_exu_pipe_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (200-bit, skid, 16-bit counter)
  logic         fl_a = 1'b0;
  logic         iv_a = 1'b0;
  logic         ir_a;
  logic [199:0] id_a = '0;
  logic         ov_a;
  logic         ordy_a = 1'b0;
  logic [199:0] od_a;
  logic [1:0]   cnt_a;
  logic [15:0]  st_a;

  // Instance B: no skid, 4-bit counter
  logic         fl_b = 1'b0;
  logic         iv_b = 1'b0;
  logic         ir_b;
  logic [7:0]   id_b = '0;
  logic         ov_b;
  logic         ordy_b = 1'b0;
  logic [7:0]   od_b;
  logic [1:0]   cnt_b;
  logic [3:0]   st_b;

  exu_pipe_reg u_a (
    .clock(clk), .reset(rst_n), .flush_i(fl_a),
    .in_valid_i(iv_a), .in_ready_o(ir_a), .in_data_i(id_a),
    .out_valid_o(ov_a), .out_ready_i(ordy_a), .out_data_o(od_a),
    .count_o(cnt_a), .stall_cnt_o(st_a)
  );

  exu_pipe_reg #(
    .PAYLOAD_W(8), .SKID_EN(1'b0), .CNT_W(4)
  ) u_b (
    .clock(clk), .reset(rst_n), .flush_i(fl_b),
    .in_valid_i(iv_b), .in_ready_o(ir_b), .in_data_i(id_b),
    .out_valid_o(ov_b), .out_ready_i(ordy_b), .out_data_o(od_b),
    .count_o(cnt_b), .stall_cnt_o(st_b)
  );

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [199:0] act,
                     input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards and stall models, sampled on the falling edge.
  logic [199:0] qa[$];
  logic [7:0]   qb[$];
  logic [15:0]  exp_st_a = '0;
  logic [3:0]   exp_st_b = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      exp_st_a = '0;
    end else if (mon_en) begin
      chk("sb_a_count", 200'(cnt_a), 200'(qa.size()));
      chk("sb_a_valid", 200'(ov_a), 200'(qa.size() != 0));
      chk("sb_a_ready", 200'(ir_a), 200'(qa.size() != 2));
      chk("sb_a_stall", 200'(st_a), 200'(exp_st_a));
      if (ov_a && ordy_a && qa.size() != 0) begin
        chk("sb_a_data", od_a, qa[0]);
        void'(qa.pop_front());
      end
      if (ov_a && !ordy_a && !fl_a && exp_st_a != 16'hFFFF)
        exp_st_a = exp_st_a + 16'd1;
      if (fl_a) qa.delete();
      else if (iv_a && ir_a) qa.push_back(id_a);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      qb.delete();
      exp_st_b = '0;
    end else if (mon_en) begin
      chk("sb_b_count", 200'(cnt_b), 200'(qb.size()));
      chk("sb_b_valid", 200'(ov_b), 200'(qb.size() != 0));
      chk("sb_b_ready", 200'(ir_b),
          200'(qb.size() == 0 || ordy_b));
      chk("sb_b_stall", 200'(st_b), 200'(exp_st_b));
      if (ov_b && ordy_b && qb.size() != 0) begin
        chk("sb_b_data", 200'(od_b), 200'(qb[0]));
        void'(qb.pop_front());
      end
      if (ov_b && !ordy_b && !fl_b && exp_st_b != 4'hF)
        exp_st_b = exp_st_b + 4'd1;
      if (fl_b) qb.delete();
      else if (iv_b && ir_b) qb.push_back(id_b);
    end
  end

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic [1:0] cnt;
    logic       ov;
    logic       ir;
    logic [7:0] od;
    logic [15:0] st;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // iv d ordy fl | count ov ir od stall (after edge)
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 8'h11, 16'd0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 8'h11, 16'd1};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 8'h11, 16'd2};
    tbl[3]  = '{1'b1, 8'h33, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 8'h11, 16'd3};
    tbl[4]  = '{1'b1, 8'h33, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'h22, 16'd3};
    tbl[5]  = '{1'b1, 8'h33, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'h33, 16'd3};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h33, 16'd3};
    tbl[7]  = '{1'b1, 8'h55, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 8'h55, 16'd3};
    tbl[8]  = '{1'b1, 8'h66, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 8'h55, 16'd4};
    tbl[9]  = '{1'b1, 8'h44, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 8'h55, 16'd4};
    tbl[10] = '{1'b1, 8'h77, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 8'h55, 16'd4};
    tbl[11] = '{1'b1, 8'h88, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'h88, 16'd4};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'h88, 16'd4};
    tbl[13] = '{1'b1, 8'h99, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 8'h99, 16'd4};
    tbl[14] = '{1'b1, 8'hAA, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 8'h99, 16'd4};

    // Reset held with traffic offered.
    iv_a = 1'b1; id_a = 200'hFF;
    iv_b = 1'b1; id_b = 8'hFF;
    repeat (3) step();
    chk("rst_a_valid", 200'(ov_a), 200'(0));
    chk("rst_a_count", 200'(cnt_a), 200'(0));
    chk("rst_a_ready", 200'(ir_a), 200'(1));
    chk("rst_a_stall", 200'(st_a), 200'(0));
    chk("rst_a_data", od_a, 200'(0));
    chk("rst_b_valid", 200'(ov_b), 200'(0));
    chk("rst_b_data", 200'(od_b), 200'(0));
    iv_a = 1'b0; iv_b = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Streaming, one-cycle latency.
    ordy_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iv_a = 1'b1;
      id_a = 200'(8'hA1 + i);
      #1;
      chk("strm_ready", 200'(ir_a), 200'(1));
      step();
      chk("strm_data", od_a, 200'(8'hA1 + i));
      chk("strm_count", 200'(cnt_a), 200'(1));
    end
    iv_a = 1'b0;
    step();
    chk("strm_drain", 200'(cnt_a), 200'(0));

    // Backpressure and flush vectors.
    for (int i = 0; i < 15; i++) begin
      iv_a = tbl[i].iv;
      id_a = 200'(tbl[i].d);
      ordy_a = tbl[i].ordy;
      fl_a = tbl[i].fl;
      step();
      chk($sformatf("v%0d_count", i), 200'(cnt_a), 200'(tbl[i].cnt));
      chk($sformatf("v%0d_valid", i), 200'(ov_a), 200'(tbl[i].ov));
      chk($sformatf("v%0d_ready", i), 200'(ir_a), 200'(tbl[i].ir));
      chk($sformatf("v%0d_data", i), od_a, 200'(tbl[i].od));
      chk($sformatf("v%0d_stall", i), 200'(st_a), 200'(tbl[i].st));
    end
    fl_a = 1'b0;

    // Reset while holding two beats drops them.
    iv_a = 1'b1; id_a = 200'hC1; ordy_a = 1'b0;
    step();
    id_a = 200'hC2;
    step();
    chk("mid_full", 200'(cnt_a), 200'(2));
    iv_a = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_count", 200'(cnt_a), 200'(0));
    chk("mid_valid", 200'(ov_a), 200'(0));
    chk("mid_data", od_a, 200'(0));
    chk("mid_stall", 200'(st_a), 200'(0));
    chk("mid_ready", 200'(ir_a), 200'(1));

    // No-skid: ready follows downstream, no bubble on replace.
    iv_b = 1'b1; id_b = 8'h5A; ordy_b = 1'b0;
    step();
    chk("ns_count", 200'(cnt_b), 200'(1));
    chk("ns_data0", 200'(od_b), 200'(8'h5A));
    chk("ns_ready0", 200'(ir_b), 200'(0));
    id_b = 8'h5B; ordy_b = 1'b1;
    #1;
    chk("ns_ready1", 200'(ir_b), 200'(1));
    step();
    chk("ns_data1", 200'(od_b), 200'(8'h5B));
    chk("ns_valid1", 200'(ov_b), 200'(1));

    // Saturating 4-bit stall counter.
    iv_b = 1'b0; ordy_b = 1'b0;
    repeat (15) step();
    chk("sat_15", 200'(st_b), 200'(15));
    repeat (5) step();
    chk("sat_hold", 200'(st_b), 200'(15));
    chk("sat_data", 200'(od_b), 200'(8'h5B));
    ordy_b = 1'b1;
    ordy_a = 1'b1;
    repeat (2) step();
    chk("end_b_count", 200'(cnt_b), 200'(0));
    chk("end_qa", 200'(qa.size()), 200'(0));
    chk("end_qb", 200'(qb.size()), 200'(0));
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
